// File: rtl/store_m_pkg.sv
// Shared constants and state type for the tiled matrix store path.
package store_m_pkg;
  localparam int TILE_WIDTH = 256;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_BYTES  = TILE_WIDTH / 8;
  localparam int ADDR_W     = 24;
  localparam int DIM_W      = 10;
  localparam int BCNT_W     = $clog2(NUM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TILE,
    S_WRITING,
    S_NEXT_TILE,
    S_NEXT_ROW,
    S_DONE
  } xfer_state_t;

  // One extra bit so cols=1023 yields 32 tiles without overflow.
  function automatic logic [DIM_W:0] tiles_for(input logic [DIM_W-1:0] n);
    return ({1'b0, n} + (DIM_W+1)'(NUM_BYTES - 1)) >> BCNT_W;
  endfunction
endpackage

// File: rtl/store_m_if.sv
// Command, tile stream and byte write port of store_m.
interface store_m_if;
  import store_m_pkg::*;

  logic                  valid_in;
  logic [ADDR_W-1:0]     dram_addr;
  logic [DIM_W-1:0]      rows;
  logic [DIM_W-1:0]      cols;
  logic [TILE_WIDTH-1:0] tile_in;
  logic                  tile_valid;
  logic                  tile_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  valid_out;

  modport master (
    output valid_in, dram_addr, rows, cols, tile_in, tile_valid,
    input  tile_ready, mem_we, mem_addr, mem_din, valid_out
  );

  modport slave (
    input  valid_in, dram_addr, rows, cols, tile_in, tile_valid,
    output tile_ready, mem_we, mem_addr, mem_din, valid_out
  );
endinterface

// File: rtl/store_m_serializer.sv
// Buffers one tile and presents its bytes in order, flagging the last valid one.
module store_m_serializer
  import store_m_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [TILE_WIDTH-1:0] tile,
  input  logic [BCNT_W:0]       count,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  last
);
  logic [TILE_WIDTH-1:0] tile_q;
  logic [BCNT_W-1:0]     byte_cnt;
  logic [BCNT_W:0]       count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_q   <= '0;
      byte_cnt <= '0;
      count_q  <= '0;
    end else if (load) begin
      tile_q   <= tile;
      byte_cnt <= '0;
      count_q  <= count;
    end else if (step) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign byte_out = tile_q[{byte_cnt, 3'b000} +: DATA_WIDTH];
  assign last     = ({1'b0, byte_cnt} + 1'b1) == count_q;
endmodule

// File: rtl/store_m.sv
// Writes a padded tile stream back to byte memory, dropping row padding.
// state       | meaning
// S_IDLE      | wait for start command, latch parameters
// S_WAIT_TILE | tile_ready high, wait for a tile handshake
// S_WRITING   | one byte write per cycle from the buffered tile
// S_NEXT_TILE | advance tile-in-row, decide end of row
// S_NEXT_ROW  | advance row, decide end of matrix
// S_DONE      | one-cycle valid_out pulse
module store_m
  import store_m_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  store_m_if.slave  bus
);
  xfer_state_t           state;
  logic [DIM_W-1:0]      rows_q, cols_q, row, col_in_row;
  logic [DIM_W:0]        tpr_q, tile_in_row;
  logic [ADDR_W-1:0]     wr_ptr, mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_din_q, ser_byte;
  logic                  mem_we_q, valid_out_q, ser_last, hs;
  logic [DIM_W-1:0]      rem;
  logic [BCNT_W:0]       ser_count;

  assign bus.tile_ready = (state == S_WAIT_TILE);
  assign hs             = bus.tile_ready & bus.tile_valid;
  assign rem            = cols_q - col_in_row;
  assign ser_count      = (rem >= DIM_W'(NUM_BYTES)) ? (BCNT_W+1)'(NUM_BYTES) : rem[BCNT_W:0];

  store_m_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hs),
    .step     (state == S_WRITING),
    .tile     (bus.tile_in),
    .count    (ser_count),
    .byte_out (ser_byte),
    .last     (ser_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      tpr_q       <= '0;
      wr_ptr      <= '0;
      row         <= '0;
      tile_in_row <= '0;
      col_in_row  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      valid_out_q <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      valid_out_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.valid_in) begin
          rows_q      <= bus.rows;
          cols_q      <= bus.cols;
          tpr_q       <= tiles_for(bus.cols);
          wr_ptr      <= bus.dram_addr;
          row         <= '0;
          tile_in_row <= '0;
          col_in_row  <= '0;
          state       <= (bus.rows == '0 || bus.cols == '0) ? S_DONE : S_WAIT_TILE;
        end
        S_WAIT_TILE: if (bus.tile_valid) state <= S_WRITING;
        S_WRITING: begin
          mem_we_q   <= 1'b1;
          mem_addr_q <= wr_ptr;
          mem_din_q  <= ser_byte;
          wr_ptr     <= wr_ptr + 1'b1;
          col_in_row <= col_in_row + 1'b1;
          if (ser_last) state <= S_NEXT_TILE;
        end
        S_NEXT_TILE: begin
          tile_in_row <= tile_in_row + 1'b1;
          state <= (tile_in_row + 1'b1 >= tpr_q) ? S_NEXT_ROW : S_WAIT_TILE;
        end
        S_NEXT_ROW: begin
          row         <= row + 1'b1;
          col_in_row  <= '0;
          tile_in_row <= '0;
          state <= (row + 1'b1 >= rows_q) ? S_DONE : S_WAIT_TILE;
        end
        S_DONE: begin
          valid_out_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.valid_out = valid_out_q;
endmodule

// File: tb/tb_store_m.sv
// Self-checking bench for store_m: table of transfers, scoreboard of expected writes.
module tb_store_m;
  import store_m_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_m_if bus();
  store_m dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [23:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    int rows; int cols; logic [23:0] base; int stall; bit mid; int seed;
    int exp_wr; int exp_tiles;
  } case_t;

  wr_t        exp_q[$];
  logic [7:0] mem [int];
  int checks = 0, errors = 0;
  int cyc = 0, wr_cnt = 0, hs_cnt = 0, done_cnt = 0, ready_cnt = 0, wait_we_cnt = 0;
  int last_hs_cyc = 0, rise_cyc = 0, last_we_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic prev_we = 1'b0;
  case_t cases[8];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] bval(input int seed, input int t, input int k);
    return 8'(seed + t * 64 + k);
  endfunction

  // Advance one clock and observe the DUT on the following falling edge.
  task automatic tick();
    logic pend;
    wr_t  e;
    pend = rst_n && bus.tile_valid && bus.tile_ready;
    @(posedge clk);
    cyc++;
    if (pend) begin hs_cnt++; last_hs_cyc = cyc; end
    @(negedge clk);
    if (bus.mem_we) begin
      wr_cnt++;
      last_we_cyc = cyc;
      if (!prev_we) rise_cyc = cyc;
      mem[int'(bus.mem_addr)] = bus.mem_din;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h want=none", bus.mem_addr, bus.mem_din);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 256'(bus.mem_addr), 256'(e.a));
        check("wr_data", 256'(bus.mem_din), 256'(e.d));
      end
    end
    prev_we = bus.mem_we;
    if (bus.tile_ready) ready_cnt++;
    if (bus.tile_ready && bus.mem_we) wait_we_cnt++;
    if (bus.valid_out) begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic start_cmd(input logic [23:0] base, input int r, input int c);
    bus.valid_in  = 1'b1;
    bus.dram_addr = base;
    bus.rows      = 10'(r);
    bus.cols      = 10'(c);
    start_cyc     = cyc;
    tick();
    bus.valid_in  = 1'b0;
  endtask

  task automatic send_tile(input logic [23:0] base, input int cols, input int r, input int t,
                           input int gidx, input int seed, input int stall);
    wr_t e;
    int  nvalid, n;
    nvalid = cols - t * 32;
    if (nvalid > 32) nvalid = 32;
    for (int k = 0; k < 32; k++) bus.tile_in[k*8 +: 8] = bval(seed, gidx, k);
    for (int k = 0; k < nvalid; k++) begin
      e.a = 24'(base + r * cols + t * 32 + k);
      e.d = bval(seed, gidx, k);
      exp_q.push_back(e);
    end
    n = 0;
    while (!bus.tile_ready && n < 200) begin tick(); n++; end
    if (!bus.tile_ready) begin
      checks++; errors++;
      $display("FAIL tile_ready_timeout got=0 want=1");
    end
    repeat (stall) tick();
    bus.tile_valid = 1'b1;
    tick();
    bus.tile_valid = 1'b0;
  endtask

  task automatic run_case(input case_t c);
    int w0, h0, d0, r0, ww0, tpr, n;
    w0 = wr_cnt; h0 = hs_cnt; d0 = done_cnt; r0 = ready_cnt; ww0 = wait_we_cnt;
    tpr = (c.cols + 31) / 32;
    start_cmd(c.base, c.rows, c.cols);
    if (c.rows != 0 && c.cols != 0) begin
      for (int r = 0; r < c.rows; r++)
        for (int t = 0; t < tpr; t++) begin
          send_tile(c.base, c.cols, r, t, r * tpr + t, c.seed, c.stall);
          if (c.mid && r == 0 && t == 0) begin
            tick();
            bus.valid_in = 1'b1; bus.dram_addr = 24'hABCDEF; bus.rows = 10'd1; bus.cols = 10'd1;
            tick();
            bus.valid_in = 1'b0; bus.dram_addr = c.base;
          end
        end
    end
    n = 0;
    while (done_cnt == d0 && n < 300) begin tick(); n++; end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL done_timeout got=0 want=1");
    end
    repeat (3) tick();
    check("write_count", 256'(wr_cnt - w0), 256'(c.exp_wr));
    check("queue_left", 256'(exp_q.size()), 256'(0));
    check("done_pulses", 256'(done_cnt - d0), 256'(1));
    check("handshakes", 256'(hs_cnt - h0), 256'(c.exp_tiles));
    check("we_in_wait", 256'(wait_we_cnt - ww0), 256'(0));
    if (c.exp_tiles == 0) begin
      check("ready_zero", 256'(ready_cnt - r0), 256'(0));
      check("done_latency", 256'(done_cyc - start_cyc), 256'(2));
    end
    if (c.exp_tiles == 1) begin
      check("first_we_latency", 256'(rise_cyc - last_hs_cyc), 256'(1));
      check("burst_len", 256'(last_we_cyc - rise_cyc), 256'(c.exp_wr - 1));
    end
    exp_q.delete();
  endtask

  initial begin
    logic [255:0] got, want;
    int w0, d0, n;
    int col;
    cases[0] = '{rows: 2, cols: 40, base: 24'h000100, stall: 0, mid: 0, seed: 0,  exp_wr: 80,  exp_tiles: 4};
    cases[1] = '{rows: 1, cols: 32, base: 24'hFFFFF0, stall: 0, mid: 0, seed: 5,  exp_wr: 32,  exp_tiles: 1};
    cases[2] = '{rows: 3, cols: 0,  base: 24'h000200, stall: 0, mid: 0, seed: 0,  exp_wr: 0,   exp_tiles: 0};
    cases[3] = '{rows: 0, cols: 5,  base: 24'h000300, stall: 0, mid: 0, seed: 0,  exp_wr: 0,   exp_tiles: 0};
    cases[4] = '{rows: 1, cols: 64, base: 24'h001000, stall: 5, mid: 1, seed: 17, exp_wr: 64,  exp_tiles: 2};
    cases[5] = '{rows: 4, cols: 50, base: 24'h002000, stall: 0, mid: 0, seed: 99, exp_wr: 200, exp_tiles: 8};
    cases[6] = '{rows: 2, cols: 1,  base: 24'h000010, stall: 2, mid: 0, seed: 3,  exp_wr: 2,   exp_tiles: 2};
    cases[7] = '{rows: 1, cols: 33, base: 24'h003000, stall: 1, mid: 0, seed: 40, exp_wr: 33,  exp_tiles: 2};

    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.dram_addr = '0; bus.rows = '0; bus.cols = '0;
    bus.tile_in = '0; bus.tile_valid = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 256'({bus.tile_ready, bus.mem_we, bus.mem_addr, bus.mem_din, bus.valid_out}), 256'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_case(cases[i]);
      if (i == 5) begin
        for (int r = 0; r < 4; r++)
          for (int t = 0; t < 2; t++) begin
            got = '0; want = '0;
            for (int k = 0; k < 32; k++) begin
              col = t * 32 + k;
              if (col < 50) begin
                want[k*8 +: 8] = bval(99, r * 2 + t, k);
                got[k*8 +: 8] = mem.exists(int'(24'h002000) + r * 50 + col) ?
                                mem[int'(24'h002000) + r * 50 + col] : 8'hxx;
              end
            end
            check("roundtrip_tile", got, want);
          end
      end
    end

    // Reset in the middle of a tile, then a fresh short transfer.
    w0 = wr_cnt;
    start_cmd(24'h000500, 1, 32);
    send_tile(24'h000500, 32, 0, 0, 0, 7, 0);
    n = 0;
    while (wr_cnt - w0 < 10 && n < 100) begin tick(); n++; end
    check("writes_before_reset", 256'(wr_cnt - w0), 256'(10));
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 256'({bus.tile_ready, bus.mem_we, bus.mem_addr, bus.mem_din, bus.valid_out}), 256'(0));
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    repeat (40) tick();
    check("no_write_after_reset", 256'(wr_cnt - w0), 256'(0));
    check("no_done_after_reset", 256'(done_cnt - d0), 256'(0));
    run_case('{rows: 1, cols: 8, base: 24'h000600, stall: 0, mid: 0, seed: 21, exp_wr: 8, exp_tiles: 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
